// File: rtl/rv_timer_multi.sv
// Multi-channel RISC-V style timer: one prescaled 64-bit mtime shared by N_TIMERS comparators,
// with a registered single-cycle register interface and W1C interrupt state.
module rv_timer_multi #(
    parameter int unsigned N_TIMERS   = 4,
    parameter int unsigned PRESCALE_W = 12,
    parameter int unsigned STEP_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [9:0]          addr_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          be_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic [N_TIMERS-1:0] intr_o
);

    logic                  active_q, active_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [31:0]           shadow_q, shadow_d;
    logic [63:0]           cmp_q [N_TIMERS];
    logic [63:0]           cmp_d [N_TIMERS];
    logic [N_TIMERS-1:0]   intr_en_q, intr_en_d;
    logic [N_TIMERS-1:0]   intr_state_q, intr_state_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [7:0]          word;
    logic [3:0]          cmp_ch;
    logic                cmp_hi;
    logic                cmp_hit;
    logic                reg_ok;
    logic                acc_err;
    logic                wr_ok;
    logic [31:0]         rd_val;
    logic                tick;
    logic [N_TIMERS-1:0] hw_set;
    logic [N_TIMERS-1:0] sw_clr;
    logic [N_TIMERS-1:0] sw_test;
    logic                unused_bits;

    assign word    = addr_i[9:2];
    assign cmp_ch  = addr_i[7:4];
    assign cmp_hi  = addr_i[2];
    // CMP window is 0x100-0x1FF; only the LO/HI words of implemented channels exist.
    assign cmp_hit = (addr_i[9:8] == 2'b01) && !addr_i[3] && (32'(cmp_ch) < N_TIMERS);

    assign unused_bits = ^{addr_i[1:0], wdata_i};

    always_comb begin
        reg_ok = 1'b1;
        rd_val = '0;
        case (word)
            8'h00: rd_val[0] = active_q;
            8'h01: begin
                rd_val[PRESCALE_W-1:0] = prescale_q;
                rd_val[16+:STEP_W]     = step_q;
            end
            8'h02: rd_val = mtime_q[31:0];
            8'h03: rd_val = shadow_q;
            8'h04: rd_val[N_TIMERS-1:0] = intr_en_q;
            8'h05: rd_val[N_TIMERS-1:0] = intr_state_q;
            8'h06: rd_val = '0;
            default: begin
                if (cmp_hit) begin
                    for (int i = 0; i < N_TIMERS; i++) begin
                        if (cmp_ch == 4'(i)) begin
                            rd_val = cmp_hi ? cmp_q[i][63:32] : cmp_q[i][31:0];
                        end
                    end
                end else begin
                    reg_ok = 1'b0;
                end
            end
        endcase
    end

    assign acc_err = !reg_ok || (we_i && (be_i != 4'hF));
    assign wr_ok   = req_i && we_i && !acc_err;

    always_comb begin
        active_d   = active_q;
        prescale_d = prescale_q;
        step_d     = step_q;
        pc_d       = pc_q;
        mtime_d    = mtime_q;
        shadow_d   = shadow_q;
        cmp_d      = cmp_q;
        intr_en_d  = intr_en_q;
        rvalid_d   = req_i;
        rdata_d    = '0;
        err_d      = 1'b0;
        tick       = 1'b0;
        sw_clr     = '0;
        sw_test    = '0;

        if (req_i) begin
            err_d   = acc_err;
            rdata_d = acc_err ? 32'hFFFF_FFFF : (we_i ? 32'h0 : rd_val);
            if (!we_i && !acc_err && (word == 8'h02)) begin
                shadow_d = mtime_q[63:32];
            end
        end

        if (active_q) begin
            if (pc_q >= prescale_q) begin
                tick = 1'b1;
                pc_d = '0;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
        if (tick) begin
            mtime_d = mtime_q + 64'(step_q);
        end

        if (wr_ok) begin
            case (word)
                8'h00: active_d = wdata_i[0];
                8'h01: begin
                    prescale_d = wdata_i[PRESCALE_W-1:0];
                    step_d     = wdata_i[16+:STEP_W];
                end
                // A SW write owns its half outright; the other half keeps its old value, no carry.
                8'h02: mtime_d = {mtime_q[63:32], wdata_i};
                8'h03: mtime_d = {wdata_i, mtime_q[31:0]};
                8'h04: intr_en_d = wdata_i[N_TIMERS-1:0];
                8'h05: sw_clr = wdata_i[N_TIMERS-1:0];
                8'h06: sw_test = wdata_i[N_TIMERS-1:0];
                default: begin
                    for (int i = 0; i < N_TIMERS; i++) begin
                        if (cmp_ch == 4'(i)) begin
                            if (cmp_hi) begin
                                cmp_d[i] = {wdata_i, cmp_q[i][31:0]};
                            end else begin
                                cmp_d[i] = {cmp_q[i][63:32], wdata_i};
                            end
                        end
                    end
                end
            endcase
        end

        for (int i = 0; i < N_TIMERS; i++) begin
            hw_set[i] = (mtime_q >= cmp_q[i]);
        end
        intr_state_d = (intr_state_q & ~sw_clr) | hw_set | sw_test;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q     <= 1'b0;
            prescale_q   <= '0;
            step_q       <= STEP_W'(1);
            pc_q         <= '0;
            mtime_q      <= '0;
            shadow_q     <= '0;
            for (int i = 0; i < N_TIMERS; i++) begin
                cmp_q[i] <= '1;
            end
            intr_en_q    <= '0;
            intr_state_q <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            active_q     <= active_d;
            prescale_q   <= prescale_d;
            step_q       <= step_d;
            pc_q         <= pc_d;
            mtime_q      <= mtime_d;
            shadow_q     <= shadow_d;
            cmp_q        <= cmp_d;
            intr_en_q    <= intr_en_d;
            intr_state_q <= intr_state_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign intr_o   = intr_state_q & intr_en_q;

endmodule

// File: doc/rv_timer_multi.md
RV_TIMER_MULTI -- requirements
Module: rv_timer_multi

Interface
REQ-001 SHALL have parameter N_TIMERS, default 4, number of compare channels sharing one 64-bit mtime (legal 1..8).
REQ-002 SHALL have parameter PRESCALE_W, default 12, prescaler width (legal 1..16).
REQ-003 SHALL have parameter STEP_W, default 8, step increment width (legal 1..8).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, register access request, one access per cycle.
REQ-007 SHALL have port we_i, input, 1, 1=write, 0=read; sampled with req_i.
REQ-008 SHALL have port addr_i, input, 10, byte address; bits [1:0] ignored.
REQ-009 SHALL have port wdata_i, input, 32, write data.
REQ-010 SHALL have port be_i, input, 4, byte enables.
REQ-011 SHALL have port rvalid_o, output, 1, response valid, exactly one cycle after each req_i.
REQ-012 SHALL have port rdata_o, output, 32, read data, valid with rvalid_o.
REQ-013 SHALL have port err_o, output, 1, access error, valid with rvalid_o.
REQ-014 SHALL have port intr_o, output, N_TIMERS, per-channel interrupt = intr_state & intr_enable.

Function
REQ-015 Register map SHALL be: 0x000 CTRL[0]=active; 0x004 CFG prescale[PRESCALE_W-1:0], step[16+:STEP_W]; 0x008 MTIME_LO; 0x00C MTIME_HI; 0x010 INTR_ENABLE[N_TIMERS-1:0]; 0x014 INTR_STATE (W1C); 0x018 INTR_TEST (write-only, reads 0); 0x100+0x10*i CMP_LO[i], 0x104+0x10*i CMP_HI[i].
REQ-016 Unused bits SHALL read 0 and ignore writes.
REQ-017 Access to an unmapped address, or to CMP of channel i>=N_TIMERS, SHALL return err_o=1, rdata_o=0xFFFF_FFFF, no state change.
REQ-018 A write with be_i!=4'hF SHALL return err_o=1 and modify nothing.
REQ-019 Response SHALL be registered: rvalid_o=1 the cycle after req_i, 0 otherwise; rdata_o/err_o hold 0 when rvalid_o=0.
REQ-020 Prescaler counter pc SHALL advance only when CTRL.active=1; tick when pc>=prescale, then pc<=0 and mtime<=mtime+step; else pc<=pc+1.
REQ-021 prescale=0 SHALL tick every active cycle; lowering prescale below pc SHALL tick on the next active cycle.
REQ-022 CTRL.active=0 SHALL freeze pc and mtime (pc not cleared).
REQ-023 mtime SHALL wrap modulo 2^64; step=0 SHALL leave mtime unchanged while pc still counts.
REQ-024 Reading MTIME_LO SHALL capture mtime[63:32] into a shadow register in the same cycle; reading MTIME_HI SHALL return the shadow, giving a coherent 64-bit snapshot.
REQ-025 Writing MTIME_LO/HI SHALL replace only that half; a SW write and a tick in the same cycle SHALL leave the written value in the written half and leave the other half unchanged by the tick.
REQ-026 INTR_STATE[i] SHALL be set on every edge where registered mtime >= {CMP_HI[i],CMP_LO[i]} (unsigned 64-bit), one cycle after the values become current.
REQ-027 INTR_STATE write SHALL clear bits written 1; HW set or INTR_TEST in the same cycle SHALL win over clear.
REQ-028 INTR_TEST write SHALL set INTR_STATE bits written 1 on that edge.
REQ-029 intr_o SHALL be combinational from registered INTR_STATE and INTR_ENABLE.

Reset
REQ-030 While rst_ni=0 at an edge: CTRL=0, prescale=0, step=1, pc=0, mtime=0, shadow=0, all CMP=0xFFFF_FFFF_FFFF_FFFF, INTR_ENABLE=0, INTR_STATE=0, rvalid_o=0, rdata_o=0, err_o=0; intr_o=0 thereafter until set.
REQ-031 A request in a reset cycle SHALL be dropped with no response; reset mid-count SHALL discard the pending tick.

Verification
REQ-032 prescale=3, step=2, active=1 -> mtime increments by 2 every 4 cycles; after 40 cycles mtime=20.
REQ-033 mtime=0xFFFF_FFFF_FFFF_FFFF, step=1, prescale=0 -> next active cycle mtime=0; CMP[0]=0 -> INTR_STATE[0]=1 one cycle later.
REQ-034 CMP[2]=0x10, enable[2]=1, count past 0x10 -> intr_o[2]=1; W1C write 0x4 while mtime>=CMP -> bit stays 1; CMP[2] set to max then W1C -> intr_o[2]=0.
REQ-035 mtime=0x1_FFFF_FFFF ticking, read LO then HI -> LO=0xFFFF_FFFF, HI=0x1 (shadow), not 0x2.
REQ-036 Write CFG with be_i=4'h3 -> err_o=1, CFG unchanged; read 0x020 -> err_o=1, rdata_o=0xFFFF_FFFF; read CMP of channel N_TIMERS -> err_o=1.
REQ-037 Assert rst_ni=0 for one cycle mid-count with pending req -> no rvalid_o, all registers at REQ-030 values next cycle.
